// File: rtl/vend_machine_p.sv
// Coin-operated vending controller with configurable price and credit width.
// Coins accumulate into a credit register; one item is vended once the price
// is met and any remainder is returned greedily, one coin per cycle.
module vend_machine_p #(
  parameter int PRICE = 3,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c5,
  input  logic          c10,
  input  logic          c20,
  input  logic          cancel,
  output logic          done,
  output logic [1:0]    change,
  output logic          reject,
  output logic          busy,
  output logic [CW-1:0] credit
);

  // state  | meaning
  // ACCUM  | idle, accepting coins and cancel
  // VEND   | dispensing one item, price deducted on exit
  // CHANGE | returning remainder, one 10c/5c coin per cycle
  typedef enum logic [1:0] {ACCUM, VEND, CHANGE} state_t;

  localparam logic [CW:0]   CMAX    = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0]   PRICE_W = (CW+1)'(PRICE);
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   credit_nxt;
  logic            reject_nxt;
  logic [2:0]      coins;
  logic            any_coin;
  logic [CW:0]     sum;

  // Coin bit positions coincide with their 5-cent weights (1, 2, 4), so the
  // concatenation is already the coin total; one extra bit catches overflow.
  always_comb begin
    coins    = {c20, c10, c5};
    any_coin = |coins;
    sum      = {1'b0, credit} + (CW+1)'(coins);
  end

  // Next-state and next-credit decision for the Moore machine.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    reject_nxt = 1'b0;
    case (state)
      ACCUM: begin
        if (cancel) begin
          reject_nxt = any_coin;
          if (credit != '0) state_nxt = CHANGE;
        end else if (sum > CMAX) begin
          reject_nxt = 1'b1;
        end else begin
          credit_nxt = sum[CW-1:0];
          if (sum >= PRICE_W) state_nxt = VEND;
        end
      end
      VEND: begin
        reject_nxt = any_coin;
        credit_nxt = credit - PRICE_C;
        state_nxt  = (credit != PRICE_C) ? CHANGE : ACCUM;
      end
      CHANGE: begin
        reject_nxt = any_coin;
        credit_nxt = (credit >= TWO) ? (credit - TWO) : (credit - ONE);
        state_nxt  = (credit_nxt == '0) ? ACCUM : CHANGE;
      end
      default: begin
        state_nxt  = ACCUM;
        credit_nxt = '0;
      end
    endcase
  end

  // State, credit and all outputs registered together; outputs are decoded
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ACCUM;
      credit <= '0;
      reject <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      change <= 2'b00;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      reject <= reject_nxt;
      done   <= (state_nxt == VEND);
      busy   <= (state_nxt != ACCUM);
      if (state_nxt == CHANGE)
        change <= (credit_nxt >= TWO) ? 2'b10 : 2'b01;
      else
        change <= 2'b00;
    end
  end

endmodule

// File: tb/tb_vend_machine_p.sv
// Bench for vend_machine_p: two builds (PRICE=3/CW=6 and PRICE=7/CW=3) share
// one stimulus stream; a queue-based model predicts every output each cycle.
module tb_vend_machine_p;

  logic       clk = 1'b0;
  logic       reset, c5, c10, c20, cancel;
  logic       done0, reject0, busy0;
  logic [1:0] change0;
  logic [5:0] credit0;
  logic       done1, reject1, busy1;
  logic [1:0] change1;
  logic [2:0] credit1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vend_machine_p #(.PRICE(3), .CW(6)) dut0 (
    .clk(clk), .reset(reset), .c5(c5), .c10(c10), .c20(c20), .cancel(cancel),
    .done(done0), .change(change0), .reject(reject0), .busy(busy0), .credit(credit0)
  );

  vend_machine_p #(.PRICE(7), .CW(3)) dut1 (
    .clk(clk), .reset(reset), .c5(c5), .c10(c10), .c20(c20), .cancel(cancel),
    .done(done1), .change(change1), .reject(reject1), .busy(busy1), .credit(credit1)
  );

  // One record per future busy cycle: what done/change/credit should show.
  typedef struct {
    bit       d;
    bit [1:0] ch;
    int       cr;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   cr0 = 0, cr1 = 0;
  bit   e_done[2], e_rej[2], e_busy[2];
  bit [1:0] e_ch[2];
  int   e_cr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: an idle machine holds a credit total; a purchase or refund
  // becomes a list of output cycles to play out, during which coins bounce.
  task automatic model_step(input int idx, input bit rst, input bit k5, input bit k10,
                            input bit k20, input bit kc);
    rec_t q[$];
    int cr, price, cmax, coins, rem;
    bit rj;
    rec_t r;
    if (idx == 0) begin q = q0; cr = cr0; price = 3; cmax = 63; end
    else          begin q = q1; cr = cr1; price = 7; cmax = 7;  end
    coins = int'(k5) + 2*int'(k10) + 4*int'(k20);
    rj = 0;
    rem = 0;
    if (rst) begin
      q.delete();
      cr = 0;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
      rj = (coins > 0);
    end else if (kc) begin
      rj = (coins > 0);
      rem = cr;
      cr = 0;
    end else if (cr + coins > cmax) begin
      rj = 1;
    end else begin
      cr = cr + coins;
      if (cr >= price) begin
        r.d = 1; r.ch = 2'b00; r.cr = cr;
        q.push_back(r);
        rem = cr - price;
        cr = 0;
      end
    end
    while (rem > 0) begin
      r.d = 0; r.cr = rem;
      if (rem >= 2) begin r.ch = 2'b10; rem -= 2; end
      else          begin r.ch = 2'b01; rem -= 1; end
      q.push_back(r);
    end
    e_rej[idx] = rj;
    if (q.size() > 0) begin
      e_done[idx] = q[0].d; e_ch[idx] = q[0].ch; e_cr[idx] = q[0].cr; e_busy[idx] = 1;
    end else begin
      e_done[idx] = 0; e_ch[idx] = 2'b00; e_cr[idx] = cr; e_busy[idx] = 0;
    end
    if (idx == 0) begin q0 = q; cr0 = cr; end
    else          begin q1 = q; cr1 = cr; end
  endtask

  task automatic tick(input bit rst, input bit k5, input bit k10, input bit k20, input bit kc);
    reset = rst; c5 = k5; c10 = k10; c20 = k20; cancel = kc;
    @(posedge clk);
    model_step(0, rst, k5, k10, k20, kc);
    model_step(1, rst, k5, k10, k20, kc);
    #1;
    chk("done0",   32'(done0),   32'(e_done[0]));
    chk("change0", 32'(change0), 32'(e_ch[0]));
    chk("reject0", 32'(reject0), 32'(e_rej[0]));
    chk("busy0",   32'(busy0),   32'(e_busy[0]));
    chk("credit0", 32'(credit0), 32'(e_cr[0]));
    chk("done1",   32'(done1),   32'(e_done[1]));
    chk("change1", 32'(change1), 32'(e_ch[1]));
    chk("reject1", 32'(reject1), 32'(e_rej[1]));
    chk("busy1",   32'(busy1),   32'(e_busy[1]));
    chk("credit1", 32'(credit1), 32'(e_cr[1]));
    reset = 0; c5 = 0; c10 = 0; c20 = 0; cancel = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; c5 = 0; c10 = 0; c20 = 0; cancel = 0;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("rst_credit", 32'(credit0), 32'd0);
    chk("rst_busy",   32'(busy0),   32'd0);
    chk("rst_change", 32'(change0), 32'd0);

    // exact pay
    tick(0, 0, 1, 0, 0);
    chk("exact_cr2", 32'(credit0), 32'd2);
    tick(0, 1, 0, 0, 0);
    chk("exact_cr3", 32'(credit0), 32'd3);
    chk("exact_done", 32'(done0), 32'd1);
    tick(0, 0, 0, 0, 0);
    chk("exact_end_cr", 32'(credit0), 32'd0);
    chk("exact_end_chg", 32'(change0), 32'd0);
    idle(3);

    // overpay with mixed coins
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 1, 0);
    chk("over_done", 32'(done0), 32'd1);
    tick(0, 0, 0, 0, 0);
    chk("over_chg10", 32'(change0), 32'd2);
    chk("over_cr3", 32'(credit0), 32'd3);
    tick(0, 0, 0, 0, 0);
    chk("over_chg5", 32'(change0), 32'd1);
    chk("over_cr1", 32'(credit0), 32'd1);
    tick(0, 0, 0, 0, 0);
    chk("over_busy_end", 32'(busy0), 32'd0);
    chk("over_cr0", 32'(credit0), 32'd0);
    idle(2);

    // cancel refund with a coin in the same cycle
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 1);
    chk("cancel_rej", 32'(reject0), 32'd1);
    chk("cancel_chg", 32'(change0), 32'd2);
    chk("cancel_nodone", 32'(done0), 32'd0);
    tick(0, 0, 0, 0, 0);
    chk("cancel_cr0", 32'(credit0), 32'd0);
    idle(2);

    // busy rejection during CHANGE
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("busy_rej", 32'(reject0), 32'd1);
    chk("busy_chg", 32'(change0), 32'd1);
    tick(0, 0, 0, 0, 0);
    chk("busy_rej_clr", 32'(reject0), 32'd0);
    chk("busy_cr0", 32'(credit0), 32'd0);
    idle(2);

    // overflow on the CW=3 / PRICE=7 build
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    chk("ovf_cr4", 32'(credit1), 32'd4);
    tick(0, 0, 0, 1, 0);
    chk("ovf_hold", 32'(credit1), 32'd4);
    chk("ovf_rej", 32'(reject1), 32'd1);
    tick(0, 0, 1, 0, 0);
    chk("ovf_cr6", 32'(credit1), 32'd6);
    tick(0, 1, 0, 0, 0);
    chk("ovf_cr7", 32'(credit1), 32'd7);
    chk("ovf_done", 32'(done1), 32'd1);
    tick(0, 0, 0, 0, 0);
    chk("ovf_nochg", 32'(change1), 32'd0);
    chk("ovf_idle", 32'(busy1), 32'd0);
    idle(2);

    // reset during the first CHANGE cycle
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("rstmid_cr", 32'(credit0), 32'd0);
    chk("rstmid_chg", 32'(change0), 32'd0);
    chk("rstmid_busy", 32'(busy0), 32'd0);
    chk("rstmid_done", 32'(done0), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_machine_p.md
# vend_machine_p

Parametrised coin-operated vending controller: the successor to the fixed-price `machine` (counter + FSM) block. It accumulates 5/10/20-cent coins into a credit register, vends when credit reaches `PRICE`, and returns change one coin per cycle using a greedy order. It adds configurable price and credit width, a cancel/refund path, overflow rejection, and coin rejection while busy. It sits between the coin-acceptor pulse inputs and the dispenser/coin-return actuators.

## Interface
- `PRICE`, default 3: item price in 5-cent units. Legal range is 1 to 2^CW−1.
- `CW`, default 6: credit register width, in 5-cent units.
- `clk` input, 1 bit: sole clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `c5` input, 1 bit: 5-cent coin pulse, one cycle per coin.
- `c10` input, 1 bit: 10-cent coin pulse.
- `c20` input, 1 bit: 20-cent coin pulse.
- `cancel` input, 1 bit: refund request, one-cycle pulse.
- `done` output, 1 bit: vend strobe, high for one cycle per item.
- `change` output, 2 bits: coin returned this cycle. `00` = none, `01` = 5c, `10` = 10c, `11` is never driven.
- `reject` output, 1 bit: coin(s) sampled on the previous edge were refused and bounced.
- `busy` output, 1 bit: high while vending or dispensing change.
- `credit` output, CW bits: current credit in 5-cent units.

## Operation
- Coin values in units: c5=1, c10=2, c20=4. Simultaneous coins in one cycle are summed (max 7).
- The state machine is Moore and has three states: ACCUM, VEND, CHANGE.
- **ACCUM.** `busy`=0, `done`=0, `change`=00.
  - `cancel`=1 and credit>0: go to CHANGE (refund, no `done`). Any coin sampled in the same cycle is rejected.
  - `cancel`=1 and credit=0: no effect. Any coin sampled in the same cycle is still rejected.
  - Otherwise, let sum = credit + coins.
    - If sum > 2^CW−1, the whole coin set is rejected and credit is unchanged.
    - Otherwise credit ← sum. If sum ≥ PRICE, go to VEND.
- **VEND.** `done`=1, `busy`=1. On the edge, credit ← credit − PRICE. Then go to CHANGE if the result is >0, else to ACCUM.
- **CHANGE.** `busy`=1. `change`=10 if credit ≥ 2, else 01. On the edge, credit is decremented by 2 or 1 respectively. Leave for ACCUM on the edge where credit reaches 0.
- Any coin sampled in VEND or CHANGE is rejected. Credit is unaffected. `cancel` is ignored in VEND and CHANGE.
- Overpayment: only one item is vended per VEND. The remainder is always returned as change and never carried over.
- Arithmetic: sums use CW+1 bits for the overflow compare. Credit never wraps.

## Timing
- Reset values: state=ACCUM, `credit`=0, `done`=0, `change`=00, `reject`=0, `busy`=0.
- Reset mid-VEND or mid-CHANGE: the outstanding change is discarded, with no further `change` pulses. Reset has priority over all inputs.
- Coins are sampled at edge E. The updated `credit` is visible after E. If the price is met, `done` is high for the cycle E→E+1.
- First `change` coin: the cycle after VEND.
- Total busy cycles = 1 + number of change coins.
- `reject` is registered. It is high for exactly the one cycle after the edge that sampled the refused coin(s). Consecutive rejected cycles give consecutive `reject` cycles.
- Change coin count = ⌊r/2⌋ + (r mod 2), where r is the remainder.

## Test plan
- **Exact pay.** PRICE=3: c10 then c5, one per cycle.
  - `credit` reads 2, then 3.
  - `done`=1 for one cycle.
  - No `change` pulses; back in ACCUM with `credit`=0.
- **Overpay, mixed coins.** PRICE=3: c20 and c10 in the same cycle (sum 6).
  - `done` for one cycle.
  - `change` 10 for one cycle, then 01 for one cycle; `credit` goes 3 → 1 → 0.
  - `busy` is high for 3 cycles.
- **Cancel refund.** Credit 2 (one c10), then `cancel` together with c5.
  - `reject`=1 on the next cycle.
  - One `change`=10 pulse, no `done`, `credit` ends at 0.
- **Busy rejection.** Insert c5 while in CHANGE.
  - `reject` pulses one cycle later.
  - The change sequence and final `credit`=0 are unaltered.
- **Overflow.** Build with CW=3, PRICE=7. Feed c20 (credit 4), then c20 again.
  - The second c20 is rejected: `credit` stays 4 and `reject`=1.
  - Then c10 gives credit 6 and c5 gives credit 7, causing `done` with no change.
- **Reset mid-dispense.** Assert `reset` during the first CHANGE cycle.
  - Next cycle: `credit`=0, `change`=00, `busy`=0, `done`=0.
